// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC and drives the fetch register's
// load/hold/flush controls. It also keeps fetch and miss performance counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CACHE_READY,
    input  logic        PIPELINE_STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC,
    output logic        PC_VALID,
    output logic        STALL_INSTRUCTION_FETCH_STAGE,
    output logic        CLEAR_INSTRUCTION_FETCH_STAGE,
    output logic [31:0] FETCH_COUNT,
    output logic [15:0] MISS_COUNT
);

    localparam int unsigned PC_W   = 32;
    localparam int unsigned MISS_W = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     fetch_q, fetch_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                clear, stall, valid, accept;

    // Fetch-register controls and next-state/next-PC/counter logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fetch_d = fetch_q;
        miss_d  = miss_q;
        clear   = 1'b1;
        stall   = 1'b0;
        valid   = 1'b0;
        accept  = 1'b0;

        if (!RST) begin
            clear  = (state_q == BOOT) | BRANCH_TAKEN;
            stall  = PIPELINE_STALL & ~clear;
            valid  = (state_q != BOOT) & CACHE_READY & ~clear;
            accept = valid & ~stall;

            if (state_q == BOOT) begin
                pc_d = pc_q;
            end else if (BRANCH_TAKEN) begin
                pc_d = {BRANCH_TARGET[31:2], 2'b00};
            end else if (stall) begin
                pc_d = pc_q;
            end else if (CACHE_READY) begin
                pc_d = pc_q + PC_W'(4);
            end

            unique case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (!BRANCH_TAKEN && !PIPELINE_STALL && !CACHE_READY) begin
                        state_d = MISS;
                        if (miss_q != {MISS_W{1'b1}}) begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                MISS: begin
                    if (BRANCH_TAKEN || (CACHE_READY && !PIPELINE_STALL)) begin
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase

            if (accept) begin
                fetch_d = fetch_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fetch_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fetch_q <= fetch_d;
            miss_q  <= miss_d;
        end
    end

    assign PC                            = pc_q;
    assign PC_VALID                      = valid;
    assign STALL_INSTRUCTION_FETCH_STAGE = stall;
    assign CLEAR_INSTRUCTION_FETCH_STAGE = clear;
    assign FETCH_COUNT                   = fetch_q;
    assign MISS_COUNT                    = miss_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, free run, miss, redirects,
// PC wrap, miss-counter saturation and reset during a stalled miss.
module tb_fetch_sequencer;

    logic        CLK;
    logic        RST;
    logic        CACHE_READY;
    logic        PIPELINE_STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        STALL_INSTRUCTION_FETCH_STAGE;
    logic        CLEAR_INSTRUCTION_FETCH_STAGE;
    logic [31:0] FETCH_COUNT;
    logic [15:0] MISS_COUNT;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(.RESET_VECTOR(32'h0000_0100)) dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .CACHE_READY                   (CACHE_READY),
        .PIPELINE_STALL                (PIPELINE_STALL),
        .BRANCH_TAKEN                  (BRANCH_TAKEN),
        .BRANCH_TARGET                 (BRANCH_TARGET),
        .PC                            (PC),
        .PC_VALID                      (PC_VALID),
        .STALL_INSTRUCTION_FETCH_STAGE (STALL_INSTRUCTION_FETCH_STAGE),
        .CLEAR_INSTRUCTION_FETCH_STAGE (CLEAR_INSTRUCTION_FETCH_STAGE),
        .FETCH_COUNT                   (FETCH_COUNT),
        .MISS_COUNT                    (MISS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational controls: clear, stall, valid
    task automatic ctl(input string tag, input logic c, input logic s, input logic v);
        #1;
        chk({tag, "_clear"}, 32'(CLEAR_INSTRUCTION_FETCH_STAGE), 32'(c));
        chk({tag, "_stall"}, 32'(STALL_INSTRUCTION_FETCH_STAGE), 32'(s));
        chk({tag, "_valid"}, 32'(PC_VALID), 32'(v));
    endtask

    // Advance one edge, then check registered state
    task automatic edge_chk(input string tag, input logic [31:0] pc, input logic [31:0] fc,
                            input logic [15:0] mc);
        @(posedge CLK);
        #1;
        chk({tag, "_pc"}, PC, pc);
        chk({tag, "_fetch"}, FETCH_COUNT, fc);
        chk({tag, "_miss"}, 32'(MISS_COUNT), 32'(mc));
    endtask

    task automatic drive(input logic cr, input logic ps, input logic bt, input logic [31:0] tgt);
        CACHE_READY    = cr;
        PIPELINE_STALL = ps;
        BRANCH_TAKEN   = bt;
        BRANCH_TARGET  = tgt;
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        ctl("rst_force", 1'b1, 1'b0, 1'b0);
        edge_chk("rst", 32'h100, 32'd0, 16'd0);

        // Boot cycle; a branch here is ignored
        RST = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_5000);
        ctl("boot", 1'b1, 1'b0, 1'b0);
        edge_chk("boot", 32'h100, 32'd0, 16'd0);

        // Free run
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ctl("run0", 1'b0, 1'b0, 1'b1);
        edge_chk("run1", 32'h104, 32'd1, 16'd0);
        edge_chk("run2", 32'h108, 32'd2, 16'd0);
        edge_chk("run3", 32'h10C, 32'd3, 16'd0);

        // Redirect to 0x200, then three miss cycles
        drive(1'b1, 1'b0, 1'b1, 32'h200);
        ctl("br200", 1'b1, 1'b0, 1'b0);
        edge_chk("br200", 32'h200, 32'd3, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            ctl("miss", 1'b0, 1'b0, 1'b0);
            edge_chk("miss", 32'h200, 32'd3, 16'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ctl("missend", 1'b0, 1'b0, 1'b1);
        edge_chk("missend", 32'h204, 32'd4, 16'd1);

        // Branch together with stall: branch wins
        drive(1'b1, 1'b1, 1'b1, 32'h0000_3007);
        ctl("brstall", 1'b1, 1'b0, 1'b0);
        edge_chk("brstall", 32'h3004, 32'd4, 16'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        ctl("stall_hit", 1'b0, 1'b1, 1'b1);
        edge_chk("stall_hit", 32'h3004, 32'd4, 16'd1);
        // Stall with cache not ready: no miss counted, stays in RUN
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        ctl("stall_nrdy", 1'b0, 1'b1, 1'b0);
        edge_chk("stall_nrdy", 32'h3004, 32'd4, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        edge_chk("miss2", 32'h3004, 32'd4, 16'd2);

        // Redirect during miss returns to RUN (a new miss then counts)
        drive(1'b0, 1'b0, 1'b1, 32'h400);
        ctl("brmiss", 1'b1, 1'b0, 1'b0);
        edge_chk("brmiss", 32'h400, 32'd4, 16'd2);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        edge_chk("miss3", 32'h400, 32'd4, 16'd3);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        edge_chk("miss3end", 32'h404, 32'd5, 16'd3);

        // PC wrap
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        edge_chk("brtop", 32'hFFFF_FFFC, 32'd5, 16'd3);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        edge_chk("wrap", 32'h0, 32'd6, 16'd3);

        // Preload miss counter near saturation while stalled in RUN
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        force dut.miss_q = 16'hFFFD;
        @(posedge CLK);
        #1;
        release dut.miss_q;
        chk("preload_pc", PC, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        edge_chk("sat1", 32'h0, 32'd6, 16'hFFFE);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        edge_chk("sat1r", 32'h4, 32'd7, 16'hFFFE);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        edge_chk("sat2", 32'h4, 32'd7, 16'hFFFF);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        edge_chk("sat2r", 32'h8, 32'd8, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        edge_chk("sat3", 32'h8, 32'd8, 16'hFFFF);

        // Reset while stalled in MISS
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        ctl("miss_stall", 1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        ctl("rst2_force", 1'b1, 1'b0, 1'b0);
        edge_chk("rst2", 32'h100, 32'd0, 16'd0);
        RST = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        ctl("boot2", 1'b1, 1'b0, 1'b0);
        edge_chk("boot2", 32'h100, 32'd0, 16'd0);
        ctl("run_stall2", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        edge_chk("run2b", 32'h104, 32'd1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
